// File: rtl/logicnet_input_quantizer_if.sv
// Valid/ready stream bundle: one data word per beat plus an end-of-vector marker.
// The slave side asserts ready; the master side owns valid, data and last.
interface logicnet_input_quantizer_if #(
  parameter int DW = 16
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;
  logic          last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/logicnet_input_quantizer.sv
// Thermometer-quantizes a serial feature stream into a packed code vector; output is valid one cycle after the final beat.
// Collection overlaps a held output; only the final beat stalls while the output register is still occupied.
module logicnet_input_quantizer #(
  parameter  int NUM_FEATURES = 16,
  parameter  int IN_WIDTH     = 16,
  parameter  int BW           = 2,
  localparam int NT           = 2**BW - 1,
  localparam int NTHR         = NUM_FEATURES * NT,
  localparam int AW           = $clog2(NTHR)
) (
  input  logic                        clk,
  input  logic                        rst,
  logicnet_input_quantizer_if.slave   s,
  logicnet_input_quantizer_if.master  m,
  input  logic                        thr_we,
  input  logic [AW-1:0]               thr_addr,
  input  logic [IN_WIDTH-1:0]         thr_data,
  output logic                        err
);

  localparam int IW = $clog2(NUM_FEATURES);
  localparam int VW = NUM_FEATURES * BW;

  logic [IN_WIDTH-1:0] thr [NTHR];
  logic [IW-1:0]       idx;
  logic [VW-1:0]       asm_q;
  logic [VW-1:0]       asm_next;
  logic [VW-1:0]       m_data_q;
  logic                m_valid_q;
  logic [BW-1:0]       code;
  logic                last_slot;
  logic                fire;
  logic                beat_final;
  logic                beat_bad;

  assign last_slot  = (idx == IW'(NUM_FEATURES - 1));
  assign s.ready    = !(last_slot && m_valid_q && !m.ready);
  assign fire       = s.valid && s.ready;
  assign beat_final = fire && s.last && last_slot;
  assign beat_bad   = fire && (s.last != last_slot);

  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.last  = 1'b1;

  // Count thresholds at or below the sample; with sorted thresholds this is the thermometer code.
  always_comb begin
    code = '0;
    for (int k = 0; k < NT; k++) begin
      if (s.data >= thr[AW'(int'(idx) * NT + k)]) begin
        code = code + BW'(1);
      end
    end
  end

  always_comb begin
    asm_next = asm_q;
    asm_next[idx * BW +: BW] = code;
  end

  // A write landing with a beat of the same feature only takes effect after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTHR; i++) begin
        thr[i] <= '0;
      end
    end else if (thr_we && (int'(thr_addr) < NTHR)) begin
      thr[thr_addr] <= thr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      asm_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err       <= 1'b0;
    end else begin
      if (beat_final) begin
        m_data_q  <= asm_next;
        m_valid_q <= 1'b1;
      end else if (m_valid_q && m.ready) begin
        m_valid_q <= 1'b0;
      end

      if (beat_final || beat_bad) begin
        idx   <= '0;
        asm_q <= '0;
      end else if (fire) begin
        idx   <= idx + IW'(1);
        asm_q <= asm_next;
      end

      if (beat_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule
